shift_sub_divider: RTL
======================

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 32, giving the dividend, divisor, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; held high until done is seen, then dropped.
REQ-005 The block SHALL have port div_signed, input, 1 bit: 1 = signed two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-006 The block SHALL have port a, input, OPERAND_WIDTH bits: dividend.
REQ-007 The block SHALL have port b, input, OPERAND_WIDTH bits: divisor.
REQ-008 The block SHALL have port q, output, OPERAND_WIDTH bits: quotient, valid only while done = 1.
REQ-009 The block SHALL have port r, output, OPERAND_WIDTH bits: remainder, valid only while done = 1.
REQ-010 The block SHALL have port done, output, 1 bit: result valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE with start = 1, the block SHALL capture a, b and div_signed into internal registers; input changes after capture SHALL be ignored until the next IDLE.
REQ-013 At capture, for signed mode, operands SHALL be converted to magnitudes.
REQ-014 At capture, the block SHALL record neg_q = sign(a) XOR sign(b) (signed mode only) and neg_r = sign(a) (signed mode only).
REQ-015 At capture, the iteration counter SHALL be cleared, and the partial remainder and quotient shift register SHALL be cleared.
REQ-016 IDLE -> DONE when start = 1 and b = 0 (divide by zero).
REQ-017 IDLE -> DONE when start = 1, div_signed = 1, a = most-negative value and b = all ones (signed overflow).
REQ-018 IDLE -> CALC when start = 1 and neither special case applies.
REQ-019 IDLE SHALL hold when start = 0.
REQ-020 Each CALC cycle SHALL perform one restoring step: partial remainder = {partial remainder[W-2:0], dividend MSB}; dividend shifted left by 1.
REQ-021 In the same CALC step, if partial remainder >= divisor magnitude, it SHALL subtract the divisor and shift 1 into the quotient LSB, else shift 0.
REQ-022 The partial-remainder compare/subtract SHALL be W+1 bits wide so no carry is lost when the divisor MSB is set.
REQ-023 CALC SHALL run exactly OPERAND_WIDTH cycles, then go to DONE; start deasserting during CALC SHALL NOT abort the operation.
REQ-024 DONE SHALL hold while start = 1 and go to IDLE on the first cycle start = 0; done = 1 in every DONE cycle.
REQ-025 Latency: done SHALL assert OPERAND_WIDTH+1 cycles after the edge at which start is sampled in IDLE (normal case) and 1 cycle after (special cases).
REQ-026 Normal result: q = neg_q ? two's-complement negation of the quotient magnitude : quotient magnitude.
REQ-027 Normal result: r = neg_r ? two's-complement negation of the remainder magnitude : remainder magnitude; a zero magnitude SHALL be output as 0 regardless of sign.
REQ-028 Divide by zero (either mode): q SHALL be all ones and r SHALL be the captured a.
REQ-029 Signed overflow: q SHALL be the captured a (most-negative value) and r SHALL be 0.
REQ-030 Outside DONE, q, r and done SHALL be driven 0.
REQ-031 The result registers SHALL remain stable for the whole DONE residency.

Reset
REQ-032 On rst = 1 at a clock edge, the state SHALL become IDLE and the counter, operand, remainder, quotient and sign registers SHALL clear.
REQ-033 In the cycle after reset, done = 0, q = 0 and r = 0.
REQ-034 Reset during CALC or DONE SHALL abandon the operation with no result produced.
REQ-035 Reset asserted together with start SHALL take priority, and start SHALL be ignored that cycle.

Verification
REQ-036 Unsigned, W = 32: a = 100, b = 7, start held -> done rises 33 cycles after start is sampled with q = 14, r = 2; dropping start -> done = 0 and q = r = 0 next cycle.
REQ-037 Signed: a = 0xFFFFFFF9 (-7), b = 2 -> q = 0xFFFFFFFD (-3), r = 0xFFFFFFFF (-1); and a = 7, b = 0xFFFFFFFE -> q = 0xFFFFFFFD, r = 1.
REQ-038 Divide by zero: a = 5, b = 0, both modes -> done 1 cycle after start with q = 0xFFFFFFFF, r = 5.
REQ-039 Overflow: signed, a = 0x80000000, b = 0xFFFFFFFF -> done after 1 cycle with q = 0x80000000, r = 0; the same operands unsigned -> CALC path with q = 0, r = 0x80000000.
REQ-040 Large unsigned: a = 0xFFFFFFFF, b = 0x80000001 -> q = 1, r = 0x7FFFFFFE (checks the W+1-bit compare).
REQ-041 Robustness: rst pulsed 10 cycles into CALC -> done = 0 thereafter; a new start (a = 9, b = 3) -> q = 3, r = 0 with full latency; toggling a/b during CALC -> no effect on the result.

Source files
------------

// File: rtl/shift_sub_divider.sv
// Multi-cycle restoring divider for signed and unsigned operands.
// One quotient bit is produced per clock. Divide-by-zero and signed overflow
// skip the iteration loop and complete in a single cycle.
module shift_sub_divider #(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     div_signed,
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic [OPERAND_WIDTH-1:0] q,
    output logic [OPERAND_WIDTH-1:0] r,
    output logic                     done
);

    localparam int W  = OPERAND_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, next_state;
    logic [W-1:0]   dvd_reg;   // dividend magnitude, shifted out MSB first
    logic [W-1:0]   dsr_reg;   // divisor magnitude
    logic [W-1:0]   rem_reg;   // partial remainder
    logic [W-1:0]   quo_reg;   // quotient shift register
    logic [CW-1:0]  cnt;
    logic           neg_q;
    logic           neg_r;

    logic           is_div0;
    logic           is_ovf;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           fits;
    logic           last_step;

    // Operand classification and magnitudes are decoded from the live inputs,
    // which are only consumed in the IDLE capture cycle.
    assign is_div0 = (b == '0);
    assign is_ovf  = div_signed && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    assign a_mag   = (div_signed && a[W-1]) ? (W'(0) - a) : a;
    assign b_mag   = (div_signed && b[W-1]) ? (W'(0) - b) : b;

    // The shift-in and trial subtract are W+1 bits wide: with the divisor MSB
    // set, the shifted remainder can exceed W bits and its carry must be kept.
    assign shifted   = {rem_reg, dvd_reg[W-1]};
    assign diff      = shifted - {1'b0, dsr_reg};
    assign fits      = ~diff[W];
    assign last_step = (cnt == CW'(W - 1));

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (is_div0 || is_ovf) ? DONE : CALC;
            CALC: if (last_step) next_state = DONE;
            DONE: if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture in IDLE, one restoring step per CALC cycle,
    // hold in DONE so the result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_reg <= '0;
            dsr_reg <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        dvd_reg <= a_mag;
                        dsr_reg <= b_mag;
                        if (is_div0) begin
                            // Special results are parked directly in the
                            // quotient/remainder registers with no sign fix-up.
                            quo_reg <= '1;
                            rem_reg <= a;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                        end else if (is_ovf) begin
                            quo_reg <= a;
                            rem_reg <= '0;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                        end else begin
                            quo_reg <= '0;
                            rem_reg <= '0;
                            neg_q   <= div_signed & (a[W-1] ^ b[W-1]);
                            neg_r   <= div_signed & a[W-1];
                        end
                    end
                end
                CALC: begin
                    rem_reg <= fits ? diff[W-1:0] : shifted[W-1:0];
                    quo_reg <= {quo_reg[W-2:0], fits};
                    dvd_reg <= {dvd_reg[W-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs: sign-corrected result while in DONE, zero otherwise.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    always_comb begin
        done = 1'b0;
        q    = '0;
        r    = '0;
        if (state == DONE) begin
            done = 1'b1;
            q    = neg_q ? (W'(0) - quo_reg) : quo_reg;
            r    = neg_r ? (W'(0) - rem_reg) : rem_reg;
        end
    end

endmodule
